// File: rtl/lb_config_loader.sv
// Scan-chain configuration loader: serialises bitstream words onto SIN/SE,
// captures the previous chain contents from SOUT and gates user reset.
module lb_config_loader #(
    parameter int CHAIN_LEN = 96,
    parameter int WORD_W    = 8
) (
    input  logic              PCLK,
    input  logic              PRST,
    input  logic              START,
    input  logic              ABORT,
    input  logic [WORD_W-1:0] DIN,
    input  logic              DIN_VALID,
    output logic              DIN_READY,
    output logic              SE,
    output logic              SIN,
    input  logic              SOUT,
    output logic [WORD_W-1:0] RDATA,
    output logic              RVALID,
    output logic              BUSY,
    output logic              CFG_DONE,
    output logic              URST_OUT
);

    localparam int CW  = $clog2(CHAIN_LEN + 1);
    localparam int BW  = $clog2(WORD_W + 1);
    localparam int NW  = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int REM = CHAIN_LEN % WORD_W;

    localparam logic [CW-1:0] LEN    = CW'(CHAIN_LEN);
    localparam logic [CW-1:0] NWORDS = CW'(NW);
    localparam logic [BW-1:0] FULL   = BW'(WORD_W);
    localparam logic [BW-1:0] TAIL   = (REM == 0) ? FULL : BW'(REM);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] buf_q, buf_d;
    logic [BW-1:0]     left_q, left_d;
    logic [CW-1:0]     sent_q, sent_d;
    logic [CW-1:0]     taken_q, taken_d;
    logic [WORD_W-1:0] rb_q, rb_d;
    logic [BW-1:0]     rbn_q, rbn_d;
    logic [WORD_W-1:0] rdata_d;
    logic              rvalid_d;
    logic              se_d;
    logic              rdy_d;
    logic              accept;

    assign accept   = DIN_VALID && DIN_READY;
    assign SIN      = buf_q[WORD_W-1];
    assign BUSY     = (state_q == SHIFT);
    assign CFG_DONE = (state_q == DONE);
    assign URST_OUT = (state_q != DONE);

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        left_d   = left_q;
        sent_d   = sent_q;
        taken_d  = taken_q;
        rb_d     = rb_q;
        rbn_d    = rbn_q;
        rdata_d  = RDATA;
        rvalid_d = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (START && !ABORT) begin
                    state_d = SHIFT;
                    buf_d   = '0;
                    left_d  = '0;
                    sent_d  = '0;
                    taken_d = '0;
                    rb_d    = '0;
                    rbn_d   = '0;
                end
            end
            SHIFT: begin
                if (SE) begin
                    buf_d  = {buf_q[WORD_W-2:0], 1'b0};
                    left_d = left_q - BW'(1);
                    sent_d = sent_q + CW'(1);
                    rb_d   = {rb_q[WORD_W-2:0], SOUT};
                    rbn_d  = rbn_q + BW'(1);
                end
                // the final word may be short; only its top bits count
                if (accept) begin
                    buf_d   = DIN;
                    left_d  = (taken_q == NWORDS - CW'(1)) ? TAIL : FULL;
                    taken_d = taken_q + CW'(1);
                end
                if (SE && (rbn_d == FULL || sent_d == LEN)) begin
                    rvalid_d = 1'b1;
                    rdata_d  = rb_d << (FULL - rbn_d);
                    rbn_d    = '0;
                end
                if (sent_d == LEN) begin
                    state_d = DONE;
                end
                if (ABORT) begin
                    state_d  = IDLE;
                    rvalid_d = 1'b0;
                    rdata_d  = RDATA;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // outputs are registered from the next-state view of the counters
    always_comb begin
        se_d  = (state_d == SHIFT) && (left_d != '0) && (sent_d < LEN);
        rdy_d = (state_d == SHIFT) && (taken_d < NWORDS)
             && ((left_d == '0) || ((left_d == BW'(1)) && se_d));
    end

    always_ff @(posedge PCLK) begin
        if (PRST) begin
            state_q   <= IDLE;
            buf_q     <= '0;
            left_q    <= '0;
            sent_q    <= '0;
            taken_q   <= '0;
            rb_q      <= '0;
            rbn_q     <= '0;
            RDATA     <= '0;
            RVALID    <= 1'b0;
            SE        <= 1'b0;
            DIN_READY <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            left_q    <= left_d;
            sent_q    <= sent_d;
            taken_q   <= taken_d;
            rb_q      <= rb_d;
            rbn_q     <= rbn_d;
            RDATA     <= rdata_d;
            RVALID    <= rvalid_d;
            SE        <= se_d;
            DIN_READY <= rdy_d;
        end
    end

endmodule

// File: tb/tb_lb_config_loader.sv
// Randomised scoreboard bench for lb_config_loader across three
// chain/word geometries, each with its own logic-block chain model.
module tb_lb_config_loader;

    bit PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input int g, input string nm,
                                input logic [63:0] act,
                                input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL inst%0d %s got=%0h want=%0h", g, nm, act, exp);
        end
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int L  = (g == 0) ? 96 : (g == 1) ? 20 : 13;
        localparam int W  = (g == 2) ? 4 : 8;
        localparam int NW = (L + W - 1) / W;

        logic         PRST, START, ABORT, DIN_VALID, DIN_READY;
        logic         SE, SIN, SOUT, RVALID, BUSY, CFG_DONE, URST_OUT;
        logic [W-1:0] DIN, RDATA;

        lb_config_loader #(.CHAIN_LEN(L), .WORD_W(W)) u_dut (
            .PCLK(PCLK), .PRST(PRST), .START(START), .ABORT(ABORT),
            .DIN(DIN), .DIN_VALID(DIN_VALID), .DIN_READY(DIN_READY),
            .SE(SE), .SIN(SIN), .SOUT(SOUT), .RDATA(RDATA),
            .RVALID(RVALID), .BUSY(BUSY), .CFG_DONE(CFG_DONE),
            .URST_OUT(URST_OUT)
        );

        // the logic block's scan chain
        logic [L-1:0] chain = '0;
        always @(posedge PCLK) if (SE) chain <= {chain[L-2:0], SIN};
        assign SOUT = chain[L-1];

        bit           sin_q[$];
        logic [W-1:0] rd_q[$];
        logic [W-1:0] wq[$];
        bit           mchain[$];
        int           se_cnt, gap_cnt, acc_cnt, run;
        bit           seen, fin;

        initial forever begin
            @(negedge PCLK);
            if (SE) begin
                chk(g, "sin_pending", sin_q.size() != 0, 1);
                if (sin_q.size() != 0) chk(g, "sin", SIN, sin_q.pop_front());
                se_cnt++;
                if (seen) gap_cnt += run;
                run  = 0;
                seen = 1;
            end else if (BUSY && seen) begin
                run++;
            end
            if (!BUSY) begin
                seen = 0;
                run  = 0;
            end
            if (RVALID) begin
                chk(g, "rd_pending", rd_q.size() != 0, 1);
                if (rd_q.size() != 0) chk(g, "rdata", RDATA, rd_q.pop_front());
            end
            if (DIN_READY && DIN_VALID) acc_cnt++;
            chk(g, "urst_vs_done", URST_OUT, !CFG_DONE);
            chk(g, "rdy_outside_shift", DIN_READY & ~BUSY, 0);
            chk(g, "se_outside_shift", SE & ~BUSY, 0);
        end

        task automatic chk_quiet(input string tag, input bit after_rst);
            chk(g, {tag, "_se"}, SE, 0);
            chk(g, {tag, "_rdy"}, DIN_READY, 0);
            chk(g, {tag, "_rvalid"}, RVALID, 0);
            chk(g, {tag, "_busy"}, BUSY, 0);
            chk(g, {tag, "_done"}, CFG_DONE, 0);
            chk(g, {tag, "_urst"}, URST_OUT, 1);
            if (after_rst) begin
                chk(g, {tag, "_sin"}, SIN, 0);
                chk(g, {tag, "_rdata"}, RDATA, 0);
            end
        endtask

        // kind: 0 complete pass, 1 ABORT after kill_at SE cycles, 2 PRST
        task automatic run_pass(input int stall_at, input int stall_len,
                                input int kill_at, input int kind);
            int           nb, nrw, i, n, stl, cyc, se0, gap0, acc0;
            bit           acc, stalling, done;
            bit           bits[$];
            logic [W-1:0] w;
            nb  = (kind != 0) ? kill_at : L;
            nrw = (kind != 0) ? (kill_at - 1) / W : NW;
            for (int b = 0; b < nb; b++) begin
                bits.push_back(wq[b / W][W - 1 - b % W]);
                sin_q.push_back(bits[b]);
            end
            for (int j = 0; j < nrw; j++) begin
                w = '0;
                for (int b = 0; b < W; b++)
                    if (j * W + b < L) w[W - 1 - b] = mchain[j * W + b];
                rd_q.push_back(w);
            end
            for (int b = 0; b < nb; b++) begin
                void'(mchain.pop_front());
                mchain.push_back(bits[b]);
            end
            se0  = se_cnt;
            gap0 = gap_cnt;
            acc0 = acc_cnt;
            i = 0; n = 0; stl = 0; cyc = 0;
            stalling = 0; done = 0;
            DIN = wq[0];
            DIN_VALID = 1;
            START = 1;
            @(posedge PCLK); #1;
            START = 0;
            while (!done && cyc < 2000) begin
                @(negedge PCLK);
                cyc++;
                acc = DIN_VALID && DIN_READY;
                if (SE) n++;
                if (stalling && DIN_READY) stl++;
                if (kind != 0 && n == kill_at) begin
                    if (kind == 1) ABORT = 1;
                    else PRST = 1;
                    done = 1;
                end else if (kind == 0 && CFG_DONE) begin
                    done = 1;
                end
                @(posedge PCLK); #1;
                ABORT = 0;
                PRST  = 0;
                if (acc && i < NW) begin
                    i++;
                    if (i == stall_at) stalling = 1;
                end
                if (stalling && stl >= stall_len) stalling = 0;
                DIN_VALID = !stalling;
                DIN = (i < NW) ? wq[i] : W'($urandom);
                START = (n + 2 < nb) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            START = 0;
            chk(g, "pass_finished", done, 1);
            @(negedge PCLK);
            if (kind == 0) begin
                chk(g, "se_count", se_cnt - se0, nb);
                chk(g, "se_gap", gap_cnt - gap0,
                    (stall_at > 0) ? stall_len : 0);
                chk(g, "accepts", acc_cnt - acc0, NW);
                chk(g, "done", CFG_DONE, 1);
                chk(g, "urst_low", URST_OUT, 0);
                chk(g, "busy_low", BUSY, 0);
                chk(g, "se_low", SE, 0);
                chk(g, "rdy_low", DIN_READY, 0);
                DIN_VALID = 0;
            end else begin
                chk_quiet((kind == 1) ? "abort" : "prst", kind == 2);
                DIN_VALID = 0;
                repeat (10) @(negedge PCLK);
                chk(g, "kill_se_count", se_cnt - se0, nb);
                chk(g, "kill_idle", BUSY, 0);
            end
            chk(g, "sin_left", sin_q.size(), 0);
            chk(g, "rd_left", rd_q.size(), 0);
        endtask

        task automatic fill(input int mode);
            wq.delete();
            for (int j = 0; j < NW; j++) begin
                if (mode == 0) wq.push_back(W'($urandom));
                else if (mode == 1)
                    wq.push_back((j == NW - 1) ? ~W'(12) : {W{1'b1}});
                else if (mode == 2) wq.push_back('0);
                else wq.push_back(W'(8'hA5));
            end
        endtask

        initial begin
            int sa;
            repeat (L) mchain.push_back(1'b0);
            PRST = 1; START = 0; ABORT = 0;
            DIN_VALID = 0; DIN = '0;
            repeat (3) @(posedge PCLK);
            @(negedge PCLK);
            chk_quiet("reset", 1);
            @(posedge PCLK); #1;
            PRST = 0;
            DIN_VALID = 1;
            repeat (3) begin
                @(negedge PCLK);
                chk(g, "idle_rdy", DIN_READY, 0);
                chk(g, "idle_acc", acc_cnt, 0);
            end
            DIN_VALID = 0;
            fill(1); run_pass(0, 0, 0, 0);
            fill(2); run_pass(0, 0, 0, 0);
            fill(3); run_pass(0, 0, 0, 0);
            fill(0); run_pass((NW > 3) ? 3 : 1, 5, 0, 0);
            fill(0); run_pass(0, 0, (L > 40) ? 40 : L / 2, 1);
            START = 1; ABORT = 1;
            @(posedge PCLK); #1;
            START = 0; ABORT = 0;
            repeat (2) begin
                @(negedge PCLK);
                chk_quiet("start_abort", 0);
            end
            fill(0); run_pass(0, 0, $urandom_range(2, L - 1), 2);
            repeat (6) begin
                sa = $urandom_range(0, 1) ? $urandom_range(1, NW - 1) : 0;
                fill(0); run_pass(sa, $urandom_range(1, 6), 0, 0);
            end
            fill(0); run_pass(0, 0, $urandom_range(2, L - 1), 1);
            fill(0); run_pass(0, 0, 0, 0);
            fin = 1;
        end
    end

    initial begin
        int t;
        t = 0;
        while (!(g_inst[0].fin && g_inst[1].fin && g_inst[2].fin)
               && t < 60000) begin
            @(posedge PCLK);
            t++;
        end
        chk(-1, "all_instances_finished", t < 60000, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
